// File: rtl/vga_capture_rx.sv
// 720p VGA receive side: sync-edge timing recovery and pixel write stream.
// Optional DOWNSCALE_EN selects 2x decimation into a half-size buffer.
module vga_capture_rx #(
    parameter int IMAGE_WIDTH   = 1280,
    parameter int IMAGE_HEIGHT  = 720,
    parameter int HFP_WIDTH     = 110,
    parameter int HSYNCH_WIDTH  = 40,
    parameter int HBP_WIDTH     = 220,
    parameter int VFP_HEIGHT    = 5,
    parameter int VSYNCH_HEIGHT = 5,
    parameter int VBP_HEIGHT    = 20,
    parameter int ADDR_W        = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              VGA_HS,
    input  logic              VGA_VS,
    input  logic [7:0]        VGA_R,
    input  logic [7:0]        VGA_G,
    input  logic [7:0]        VGA_B,
    output logic              pix_valid,
    output logic [10:0]       pix_x,
    output logic [9:0]        pix_y,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [23:0]       pix_data,
    output logic              frame_start,
    output logic              locked,
    output logic              sync_err
);

    localparam int H_TOTAL = IMAGE_WIDTH + HFP_WIDTH + HSYNCH_WIDTH + HBP_WIDTH;
    localparam int V_TOTAL = IMAGE_HEIGHT + VFP_HEIGHT + VSYNCH_HEIGHT + VBP_HEIGHT;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS_START = 11'(IMAGE_WIDTH + HFP_WIDTH);
    localparam logic [10:0] H_ACT    = 11'(IMAGE_WIDTH);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VS_START = 10'(IMAGE_HEIGHT + VFP_HEIGHT);
    localparam logic [9:0]  V_ACT    = 10'(IMAGE_HEIGHT);

    typedef enum logic [1:0] {
        UNLOCKED,
        H_ALIGN,
        LOCKED
    } state_t;

    state_t state, state_d;

    logic        hs_s1, hs_s2, vs_s1, vs_s2;
    logic [23:0] rgb_s1;
    logic [10:0] h_cnt, h_d;
    logic [9:0]  v_cnt, v_d;

    logic hs_rise, vs_rise, at_hs, at_vs;
    logic hs_err, vs_err, h_wrap, viol, live, act;

    logic              valid_d;
    logic [10:0]       x_d;
    logic [9:0]        y_d;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        hs_rise = hs_s1 & ~hs_s2;
        vs_rise = vs_s1 & ~vs_s2;
        at_hs   = (h_cnt == HS_START);
        at_vs   = (v_cnt == VS_START) && (h_cnt == 11'd0);
        hs_err  = hs_rise ^ at_hs;
        vs_err  = vs_rise ^ at_vs;
        h_wrap  = (h_cnt == H_LAST);
    end

    always_comb begin
        state_d = state;
        viol    = 1'b0;
        unique case (state)
            UNLOCKED: begin
                if (hs_rise) state_d = H_ALIGN;
            end
            H_ALIGN: begin
                if (hs_err) begin
                    state_d = UNLOCKED;
                end else if (vs_rise) begin
                    state_d = (h_cnt == 11'd0) ? LOCKED : UNLOCKED;
                end
            end
            LOCKED: begin
                if (hs_err || vs_err) begin
                    state_d = UNLOCKED;
                    viol    = 1'b1;
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    // counters track the stage-1 sample; an align event loads them
    always_comb begin
        h_d = h_wrap ? 11'd0 : h_cnt + 11'd1;
        v_d = v_cnt;
        if (h_wrap) v_d = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        if (state == UNLOCKED && hs_rise) h_d = HS_START + 11'd1;
        if (state == H_ALIGN && !hs_err && vs_rise && h_cnt == 11'd0) begin
            v_d = VS_START;
        end
    end

    always_comb begin
        live = (state == LOCKED) && !viol;
        act  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
`ifdef DOWNSCALE_EN
        valid_d = live && act && !h_cnt[0] && !v_cnt[0];
        x_d     = {1'b0, h_cnt[10:1]};
        y_d     = {1'b0, v_cnt[9:1]};
        addr_d  = ADDR_W'(y_d) * ADDR_W'(IMAGE_WIDTH / 2) + ADDR_W'(x_d);
`else
        valid_d = live && act;
        x_d     = h_cnt;
        y_d     = v_cnt;
        addr_d  = ADDR_W'(v_cnt) * ADDR_W'(IMAGE_WIDTH) + ADDR_W'(h_cnt);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= UNLOCKED;
        else       state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_s1       <= 1'b0;
            hs_s2       <= 1'b0;
            vs_s1       <= 1'b0;
            vs_s2       <= 1'b0;
            rgb_s1      <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_addr    <= '0;
            pix_data    <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            hs_s1       <= VGA_HS;
            hs_s2       <= hs_s1;
            vs_s1       <= VGA_VS;
            vs_s2       <= vs_s1;
            rgb_s1      <= {VGA_R, VGA_G, VGA_B};
            h_cnt       <= h_d;
            v_cnt       <= v_d;
            pix_valid   <= valid_d;
            pix_x       <= x_d;
            pix_y       <= y_d;
            pix_addr    <= addr_d;
            pix_data    <= rgb_s1;
            frame_start <= live && h_cnt == 11'd0 && v_cnt == 10'd0;
            locked      <= (state_d == LOCKED);
            sync_err    <= viol;
        end
    end

endmodule
